pe_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port 32-bit word memory (combinational read, write on posedge clk) among N_REQ processing-element requesters. Each cycle at most one requester's access is issued to the memory. Read data is registered and returned one cycle later, tagged with the requester id. A requester may lock the port for a bounded burst, e.g. the four filter words at M, M+4, M+8 and M+12.

---
 rtl/conv_mem_pkg.sv | 21 ++
 rtl/rr_pick.sv | 32 +++
 rtl/pe_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_pe_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mem_pkg.sv
// Shared types and default sizing for the PE-to-memory arbitration path.
package conv_mem_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_AW        = 32;
    localparam int DEF_DW        = 32;
    localparam int DEF_MAX_BURST = 16;

    // Requester index width; a single requester still needs one id bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W = id_width(DEF_N_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority find-first: first asserted req scanning ptr, ptr+1, ... with wrap.
// Latency: purely combinational.
// Backpressure: none; result is only meaningful when found=1.
module rr_pick
    import conv_mem_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    int j;

    // Scan from the farthest slot back to ptr so the nearest hit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                found = 1'b1;
                idx   = j[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory among N_REQ PEs, with bounded burst lock.
// Latency: access issued in the grant cycle; read data/ack returned one cycle later.
// Backpressure: requesters hold req until gnt; a locked owner keeps the port for up to MAX_BURST grants.
module pe_mem_arbiter
    import conv_mem_pkg::*;
#(
    parameter  int N_REQ     = DEF_N_REQ,
    parameter  int AW        = DEF_AW,
    parameter  int DW        = DEF_DW,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int ID_W      = id_width(N_REQ),
    localparam int BC_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ-1:0]    we,
    input  logic [N_REQ*AW-1:0] adr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic                resp_valid,
    output logic                resp_we,
    output logic [ID_W-1:0]     resp_id,
    output logic [DW-1:0]       resp_rdata,
    output logic [AW-1:0]       mem_adr,
    output logic [DW-1:0]       mem_in,
    output logic                mem_we,
    input  logic [DW-1:0]       mem_out
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [BC_W-1:0] cnt_q, cnt_d;
    logic [BC_W-1:0] cnt_inc;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            issue;
    logic            issue_ok;
    logic [ID_W-1:0] sel;

    logic            resp_valid_q;
    logic            resp_we_q;
    logic [ID_W-1:0] resp_id_q;
    logic [DW-1:0]   resp_rdata_q;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        sel     = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    issue = 1'b1;
                    sel   = pick_idx;
                    ptr_d = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    // The winning grant is burst access #1; a limit of one leaves nothing to hold.
                    if (lock[pick_idx] && (MAX_BURST > 1)) begin
                        state_d = LOCKED;
                        owner_d = pick_idx;
                        cnt_d   = BC_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (req[owner_q]) begin
                    issue = 1'b1;
                    sel   = owner_q;
                    cnt_d = cnt_inc;
                    if (!lock[owner_q] || (cnt_inc == BC_W'(MAX_BURST))) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant and write strobe are gated by reset so nothing lands in memory while held.
    assign issue_ok = issue & rst_n;

    always_comb begin
        gnt     = '0;
        mem_adr = '0;
        mem_in  = '0;
        mem_we  = 1'b0;
        if (issue_ok) begin
            gnt[sel] = 1'b1;
            mem_adr  = adr[int'(sel)*AW +: AW];
            mem_in   = wdata[int'(sel)*DW +: DW];
            mem_we   = we[sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_id_q    <= '0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= issue;
            if (issue) begin
                resp_id_q <= sel;
                resp_we_q <= we[sel];
                if (!we[sel]) begin
                    resp_rdata_q <= mem_out;
                end
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_we    = resp_we_q;
    assign resp_id    = resp_id_q;
    assign resp_rdata = resp_rdata_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_cnt_bound:  assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= BC_W'(MAX_BURST));
    a_lock_owner: assert property (@(posedge clk) disable iff (!rst_n)
                                   (state_q == LOCKED) |-> ((gnt == '0) || gnt[owner_q]));

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Bench for pe_mem_arbiter: directed table, hand-written corner sequences and a random run
// against a round-robin/lock reference model with its own shadow memory.
module tb_pe_mem_arbiter;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] adr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic            resp_valid, resp_we;
    logic [1:0]      resp_id;
    logic [DW-1:0]   resp_rdata;
    logic [AW-1:0]   mem_adr;
    logic [DW-1:0]   mem_in;
    logic            mem_we;
    logic [DW-1:0]   mem_out;

    pe_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .lock       (lock),
        .we         (we),
        .adr        (adr),
        .wdata      (wdata),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_we    (resp_we),
        .resp_id    (resp_id),
        .resp_rdata (resp_rdata),
        .mem_adr    (mem_adr),
        .mem_in     (mem_in),
        .mem_we     (mem_we),
        .mem_out    (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return (k == 5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(k));
    endfunction

    // Memory environment: combinational read, write on rising edge.
    logic [31:0] mem [0:63];
    logic        mem_init_done;
    assign mem_out = mem[mem_adr[5:0]];
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
        end else if (mem_we) begin
            mem[mem_adr[5:0]] <= mem_in;
        end
    end

    int          n_checks, n_errors;
    int          m_ptr, m_owner, m_cnt;
    logic [31:0] smem [0:63];
    logic [31:0] e_rdata;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] exp_gnt;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        m_cnt   = 0;
        e_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '1;
        lock  = '1;
        we    = '1;
        adr   = '0;
        wdata = '0;
        #1;
        chk("rst_gnt_async", gnt, 0);
        chk("rst_mem_we_async", mem_we, 0);
        @(posedge clk);
        #1;
        mem_init_done = 1'b1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_we", resp_we, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_gnt", gnt, 0);
        @(negedge clk);
        req   = '0;
        lock  = '0;
        we    = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of traffic with the current inputs; called at a falling edge.
    task automatic cycle(output int g);
        int            gi;
        logic          exp_we;
        logic [AW-1:0] exp_adr;
        logic [DW-1:0] exp_in;
        gi = -1;
        if (m_owner >= 0) begin
            if (req[m_owner]) begin
                gi = m_owner;
                m_cnt++;
                if (!lock[m_owner] || m_cnt == MAXB) m_owner = -1;
            end else begin
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < N; k++)
                if (gi < 0 && req[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
            if (gi >= 0) begin
                m_ptr = (gi + 1) % N;
                if (lock[gi] && MAXB > 1) begin
                    m_owner = gi;
                    m_cnt   = 1;
                end
            end
        end
        exp_we  = 1'b0;
        exp_adr = '0;
        exp_in  = '0;
        if (gi >= 0) begin
            exp_we  = we[gi];
            exp_adr = adr[gi*AW +: AW];
            exp_in  = wdata[gi*DW +: DW];
        end
        #1;
        chk("gnt", gnt, (gi >= 0) ? (64'd1 << gi) : 64'd0);
        chk("mem_we", mem_we, exp_we);
        chk("mem_adr", mem_adr, exp_adr);
        chk("mem_in", mem_in, exp_in);
        if (gi >= 0) begin
            if (exp_we) smem[exp_adr[5:0]] = exp_in;
            else        e_rdata = smem[exp_adr[5:0]];
        end
        @(posedge clk);
        #1;
        chk("resp_valid", resp_valid, (gi >= 0));
        if (gi >= 0) begin
            chk("resp_id", resp_id, gi);
            chk("resp_we", resp_we, exp_we);
        end
        chk("resp_rdata", resp_rdata, e_rdata);
        @(negedge clk);
        g = gi;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, last_g, cnt0;
        int seq [20];
        n_checks      = 0;
        n_errors      = 0;
        mem_init_done = 1'b0;
        for (int k = 0; k < 64; k++) smem[k] = init_word(k);

        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0101, 4'b0000, 4'b0100};
        tbl[7]  = '{4'b0101, 4'b0000, 4'b0001};
        tbl[8]  = '{4'b1001, 4'b0000, 4'b1000};
        tbl[9]  = '{4'b0010, 4'b0010, 4'b0010};
        tbl[10] = '{4'b1011, 4'b0010, 4'b0010};
        tbl[11] = '{4'b1101, 4'b0000, 4'b0000};
        tbl[12] = '{4'b1101, 4'b0000, 4'b0100};
        tbl[13] = '{4'b1001, 4'b0000, 4'b1000};

        do_reset();

        // Directed table from reset
        for (int v = 0; v < 14; v++) begin
            req  = tbl[v].req;
            lock = tbl[v].lock;
            we   = '0;
            for (int i = 0; i < N; i++) adr[i*AW +: AW] = AW'(4*i + v);
            cycle(g);
            chk("tbl_gnt", (g >= 0) ? (64'd1 << g) : 64'd0, tbl[v].exp_gnt);
        end

        // PE2 reads preloaded word alone
        do_reset();
        req = 4'b0100; adr[2*AW +: AW] = 32'd5;
        cycle(g);
        chk("pe2_gnt", g, 2);
        chk("pe2_rdata", resp_rdata, 32'hDEADBEEF);
        chk("pe2_id", resp_id, 2);

        // All four requesting continuously: strict rotation
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) adr[i*AW +: AW] = AW'(16 + 4*i + c);
            cycle(g);
            chk("rr_all", g, c % 4);
        end

        // PE1 four-word locked burst with PE0 and PE3 contending
        do_reset();
        req = 4'b0001;
        cycle(g);
        req = 4'b1011; lock = 4'b0010;
        for (int b = 0; b < 4; b++) begin
            adr[1*AW +: AW] = AW'(8 + 4*b);
            if (b == 3) lock = 4'b0000;
            cycle(g);
            chk("burst4_pe1", g, 1);
        end
        req = 4'b1001;
        cycle(g);
        chk("after_burst_pe3", g, 3);
        req = 4'b0001;
        cycle(g);
        chk("after_burst_pe0", g, 0);

        // MAX_BURST forced release
        do_reset();
        req = 4'b0011; lock = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            cycle(g);
            seq[c] = g;
            if (g == 1) req[1] = 1'b0;
        end
        cnt0 = 0;
        for (int c = 0; c < 16; c++) if (seq[c] == 0) cnt0++;
        chk("maxburst_pe0_count", cnt0, 16);
        chk("maxburst_release_pe1", seq[16], 1);

        // Write then read same address from another PE
        do_reset();
        req = 4'b1000; we = 4'b1000;
        adr[3*AW +: AW] = 32'd40; wdata[3*DW +: DW] = 32'h01020304;
        cycle(g);
        req = 4'b0001; we = 4'b0000; adr[0 +: AW] = 32'd40;
        cycle(g);
        chk("wr_rd_data", resp_rdata, 32'h01020304);
        chk("wr_rd_id", resp_id, 0);

        // Reset in the middle of a locked burst with a write pending
        do_reset();
        req = 4'b0100; lock = 4'b0100; adr[2*AW +: AW] = 32'd7;
        cycle(g);
        we = 4'b0100; adr[2*AW +: AW] = 32'd50; wdata[2*DW +: DW] = 32'hCAFEF00D;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_resp_rdata", resp_rdata, 0);
        @(posedge clk);
        #1;
        chk("midrst_mem_kept", mem[50], init_word(50));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        req = 4'b0101; lock = 4'b0000; we = 4'b0000;
        adr[0 +: AW] = 32'd1; adr[2*AW +: AW] = 32'd2;
        cycle(g);
        chk("midrst_pe0_first", g, 0);

        // Random traffic against the reference model
        do_reset();
        last_g = -1;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || last_g == i) begin
                    req[i]            = ($urandom_range(0, 3) != 0);
                    we[i]             = ($urandom_range(0, 2) == 0);
                    adr[i*AW +: AW]   = AW'($urandom_range(0, 63));
                    wdata[i*DW +: DW] = $urandom;
                end
                lock[i] = ($urandom_range(0, 2) != 0);
            end
            cycle(last_g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
